// File: rtl/banked_mem_if.sv
// Request/response bundle between the cache controller (master) and the
// banked main-memory model (slave).
interface banked_mem_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  modport master (
    output addr, data_in, rd, wr,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, rd_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_mem.sv
// Four-bank word-interleaved memory: per-bank occupancy counters, combinational
// stall/err, and a fixed two-stage read-data pipeline.
module banked_mem_bank #(
  parameter int DATA_W     = 16,
  parameter int BANK_DEPTH = 8192,
  parameter int BUSY_CYC   = 4,
  parameter int IDX_W      = $clog2(BANK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  localparam int CNT_W = $clog2(BUSY_CYC);

  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [DATA_W-1:0] mem_q [BANK_DEPTH];

  // Counter covers the accept cycle itself, so it loads BUSY_CYC-1.
  always_comb begin
    cnt_d = cnt_q;
    if (acc)
      cnt_d = CNT_W'(BUSY_CYC - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];
  assign busy  = (cnt_q != '0);
endmodule

module banked_mem #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int BANK_DEPTH = 8192,
  parameter int BUSY_CYC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  banked_mem_if.slave   bus
);
  localparam int NUM_BANKS = 4;
  localparam int IDX_W     = $clog2(BANK_DEPTH);

  logic                              req, err, stall, acc, rd_acc;
  logic [1:0]                        bank;
  logic [IDX_W-1:0]                  idx;
  logic [NUM_BANKS-1:0]              bank_acc, bank_we, bank_busy;
  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_rdata;

  logic [2:1]        vld_pipe_d, vld_pipe_q;
  logic [DATA_W-1:0] s1_data_d, s1_data_q;
  logic [DATA_W-1:0] dout_d, dout_q;

  always_comb begin
    req    = bus.rd | bus.wr;
    err    = (bus.rd & bus.wr) | (req & bus.addr[0]);
    bank   = bus.addr[2:1];
    idx    = IDX_W'(bus.addr >> 3);
    stall  = req & ~err & bank_busy[bank];
    acc    = req & ~err & ~stall;
    rd_acc = acc & bus.rd;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_acc[b] = acc & (bank == 2'(b));
      // A write landing on an edge with reset high is dropped.
      bank_we[b]  = bank_acc[b] & bus.wr & ~rst;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    banked_mem_bank #(
      .DATA_W     (DATA_W),
      .BANK_DEPTH (BANK_DEPTH),
      .BUSY_CYC   (BUSY_CYC),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .acc   (bank_acc[b]),
      .we    (bank_we[b]),
      .idx   (idx),
      .wdata (bus.data_in),
      .rdata (bank_rdata[b]),
      .busy  (bank_busy[b])
    );
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], rd_acc};
    s1_data_d  = rd_acc ? bank_rdata[bank] : s1_data_q;
    dout_d     = vld_pipe_q[1] ? s1_data_q : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_data_q  <= '0;
      dout_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_data_q  <= s1_data_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.err      = err;
  assign bus.stall    = stall;
  assign bus.busy     = bank_busy;
  assign bus.rd_valid = vld_pipe_q[2];
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem: one table row per cycle, plus hand-written
// reset-mid-read and wrap-around sequences.
module tb_banked_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_mem_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  // Reduced depth so the top word address has an in-range alias.
  banked_mem #(.ADDR_W(16), .DATA_W(16), .BANK_DEPTH(4096), .BUSY_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, din;
    logic        stall, err;
    logic [3:0]  busy;
    logic        rv;
    logic        chk_d;
    logic [15:0] dout;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din,
                     input logic stall, input logic err, input logic [3:0] busy,
                     input logic rv, input logic chk_d, input logic [15:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.stall = stall; v.err = err;
    v.busy = busy; v.rv = rv; v.chk_d = chk_d; v.dout = dout;
    tv.push_back(v);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
    bus.rd = rd; bus.wr = wr; bus.addr = addr; bus.data_in = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 16'h0, 16'h0);
    //   rd wr addr     din      stl err busy     rv cd dout
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 1, 16'h0000); // 0 idle after reset
    add(0, 1, 16'h0010, 16'hBEEF, 0, 0, 4'b0000, 0, 0, 16'h0000); // 1 write accept
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(1, 0, 16'h0010, 16'h0000, 0, 0, 4'b0000, 0, 0, 16'h0000); // 5 read accept
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 1, 16'hBEEF); // 7 data T+2
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 1, 16'hBEEF); // hold
    add(0, 1, 16'h0000, 16'h1111, 0, 0, 4'b0000, 0, 0, 16'h0000); // 9 write bank0
    add(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 0, 16'h0000); // stalled
    add(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 0, 16'h0000);
    add(1, 0, 16'h0008, 16'h0000, 1, 0, 4'b0001, 0, 0, 16'h0000);
    add(1, 0, 16'h0008, 16'h0000, 0, 0, 4'b0000, 0, 0, 16'h0000); // 13 accept T+4
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 0, 16'h0000); // 15 data T+6
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 1, 16'h0100, 16'h00A0, 0, 0, 4'b0000, 0, 0, 16'h0000); // 17 line write
    add(0, 1, 16'h0102, 16'h00A1, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 1, 16'h0104, 16'h00A2, 0, 0, 4'b0011, 0, 0, 16'h0000);
    add(0, 1, 16'h0106, 16'h00A3, 0, 0, 4'b0111, 0, 0, 16'h0000);
    add(1, 0, 16'h0100, 16'h0000, 0, 0, 4'b1110, 0, 0, 16'h0000); // 21 line read
    add(1, 0, 16'h0102, 16'h0000, 0, 0, 4'b1101, 0, 0, 16'h0000);
    add(1, 0, 16'h0104, 16'h0000, 0, 0, 4'b1011, 1, 1, 16'h00A0);
    add(1, 0, 16'h0106, 16'h0000, 0, 0, 4'b0111, 1, 1, 16'h00A1);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1110, 1, 1, 16'h00A2);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1100, 1, 1, 16'h00A3);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b1000, 0, 1, 16'h00A3);
    add(1, 1, 16'h0020, 16'h0000, 0, 1, 4'b0000, 0, 0, 16'h0000); // 28 rd&wr
    add(1, 0, 16'h0021, 16'h0000, 0, 1, 4'b0000, 0, 0, 16'h0000); // odd addr
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 1, 16'h00A3);
    add(0, 1, 16'h0200, 16'h7777, 0, 0, 4'b0000, 0, 1, 16'h00A3); // 31
    add(1, 1, 16'h0200, 16'h0000, 0, 1, 4'b0001, 0, 0, 16'h0000); // err beats stall
    add(0, 1, 16'h0201, 16'hDEAD, 0, 1, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(1, 0, 16'h0200, 16'h0000, 0, 0, 4'b0000, 0, 1, 16'h00A3); // 35
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 1, 1, 16'h7777);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0001, 0, 0, 16'h0000);
    add(0, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000, 0, 0, 16'h0000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].din);
      #1;
      chk($sformatf("v%0d stall", i), 32'(bus.stall), 32'(tv[i].stall));
      chk($sformatf("v%0d err", i), 32'(bus.err), 32'(tv[i].err));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(tv[i].busy));
      chk($sformatf("v%0d rd_valid", i), 32'(bus.rd_valid), 32'(tv[i].rv));
      if (tv[i].chk_d)
        chk($sformatf("v%0d data_out", i), 32'(bus.data_out), 32'(tv[i].dout));
      tick();
    end

    // Reset mid-read, with a write held across an edge while reset is high.
    drive(1, 0, 16'h0100, 16'h0000);
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1;
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst data_out", 32'(bus.data_out), 32'h0);
    drive(0, 1, 16'h0100, 16'hFFFF);
    tick();
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    rst = 1'b0;
    #1;
    chk("post rst rd_valid a", 32'(bus.rd_valid), 32'h0);
    tick();
    chk("post rst rd_valid b", 32'(bus.rd_valid), 32'h0);
    chk("post rst busy", 32'(bus.busy), 32'h0);
    drive(1, 0, 16'h0100, 16'h0000);
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    tick();
    chk("rst write dropped rv", 32'(bus.rd_valid), 32'h1);
    chk("rst write dropped data", 32'(bus.data_out), 32'h00A0);

    // Top word (bank 3, index 0x1FFF) aliases 0x7FFE at depth 4096.
    tick();
    tick();
    drive(0, 1, 16'hFFFE, 16'h5A5A);
    #1 chk("wrap wr stall", 32'(bus.stall), 32'h0);
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    repeat (3) tick();
    drive(1, 0, 16'h7FFE, 16'h0000);
    #1 chk("wrap rd stall", 32'(bus.stall), 32'h0);
    tick();
    drive(0, 0, 16'h0000, 16'h0000);
    tick();
    chk("wrap rd_valid", 32'(bus.rd_valid), 32'h1);
    chk("wrap data", 32'(bus.data_out), 32'h5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
